// File: rtl/iobus_timer_responder.sv
// IOBUS-mapped prescaled 32-bit down-counter timer with one-shot/auto-reload modes
// and a sticky expiry flag driving the CPU interrupt line.
module iobus_timer_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        IO_HIT,
    output logic        INTR
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_RELOAD   = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    state_e                  state_q, state_d;
    logic                    auto_reload_q, auto_reload_d;
    logic                    irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic [PRESCALE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [31:0]             reload_q, reload_d;
    logic [31:0]             count_q, count_d;
    logic                    expired_q, expired_d;
    logic [31:0]             iobus_in_q, iobus_in_d;
    logic                    io_hit_q, io_hit_d;
    logic                    intr_q, intr_d;

    logic                    hit;
    logic                    wr_en;
    logic [2:0]              off;
    logic                    running;
    logic                    tick;
    logic [31:0]             rdata;
    logic                    unused_addr_bits;

    assign hit              = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign wr_en            = hit & IOBUS_WR;
    assign off              = IOBUS_ADDR[4:2];
    assign running          = (state_q == RUN);
    assign tick             = running && (pre_cnt_q == prescale_q);
    assign unused_addr_bits = ^IOBUS_ADDR[1:0];

    // Read data always comes from pre-edge state, so same-edge writes are not visible.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:     rdata = {29'd0, irq_en_q, auto_reload_q, running};
            OFF_PRESCALE: rdata = 32'(prescale_q);
            OFF_RELOAD:   rdata = reload_q;
            OFF_COUNT:    rdata = count_q;
            OFF_STATUS:   rdata = {30'd0, running, expired_q};
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        prescale_d    = prescale_q;
        pre_cnt_d     = pre_cnt_q;
        reload_d      = reload_q;
        count_d       = count_q;
        expired_d     = expired_q;

        if (running) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
        end

        // W1C is applied before expiry so a coincident expiry keeps the flag set.
        if (wr_en && (off == OFF_STATUS) && IOBUS_OUT[0]) begin
            expired_d = 1'b0;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (auto_reload_q) begin
                    count_d = reload_q;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        // Bus writes come last so they override the counter/FSM updates above.
        if (wr_en) begin
            case (off)
                OFF_CTRL: begin
                    auto_reload_d = IOBUS_OUT[1];
                    irq_en_d      = IOBUS_OUT[2];
                    state_d       = IOBUS_OUT[0] ? RUN : IDLE;
                    if (IOBUS_OUT[0] && !running) begin
                        pre_cnt_d = '0;
                    end
                end
                OFF_PRESCALE: begin
                    prescale_d = IOBUS_OUT[PRESCALE_W-1:0];
                    pre_cnt_d  = '0;
                end
                OFF_RELOAD: reload_d = IOBUS_OUT;
                OFF_COUNT:  count_d  = IOBUS_OUT;
                default: ;
            endcase
        end

        iobus_in_d = hit ? rdata : '0;
        io_hit_d   = hit;
        intr_d     = expired_q & irq_en_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            prescale_q    <= '0;
            pre_cnt_q     <= '0;
            reload_q      <= '0;
            count_q       <= '0;
            expired_q     <= 1'b0;
            iobus_in_q    <= '0;
            io_hit_q      <= 1'b0;
            intr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            prescale_q    <= prescale_d;
            pre_cnt_q     <= pre_cnt_d;
            reload_q      <= reload_d;
            count_q       <= count_d;
            expired_q     <= expired_d;
            iobus_in_q    <= iobus_in_d;
            io_hit_q      <= io_hit_d;
            intr_q        <= intr_d;
        end
    end

    assign IOBUS_IN = iobus_in_q;
    assign IO_HIT   = io_hit_q;
    assign INTR     = intr_q;

endmodule
